// File: rtl/uart_wb_pkg.sv
// Shared types and byte constants for the UART-to-Wishbone command bridge.
// Checksum framing is enabled by defining UART_WB_CHECKSUM_EN.
package uart_wb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_DATA = 3'd2,
      ST_CHK  = 3'd3,
      ST_BUS  = 3'd4,
      ST_RESP = 3'd5
   } state_t;

   localparam logic [7:0] CMD_WR     = 8'h57;
   localparam logic [7:0] CMD_RD     = 8'h52;
   localparam logic [7:0] RSP_OK     = 8'h4B;
   localparam logic [7:0] RSP_BADCMD = 8'h3F;
   localparam logic [7:0] RSP_TMO    = 8'hEE;
   localparam logic [7:0] RSP_CHK    = 8'h45;

   function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

   // Single-byte responses travel MSB-aligned through the serializer.
   function automatic logic [31:0] rsp_word(input logic [7:0] code);
      return {code, 24'h000000};
   endfunction

endpackage

// File: rtl/uart_wb_resp_ser.sv
// Response serializer: emits the top nbytes of a 32-bit word, MSB first,
// over a tx_valid/tx_ready handshake.
module uart_wb_resp_ser
   import uart_wb_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] word,
   input  logic [2:0]  nbytes,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        done
);

   logic [23:0] sh_r;
   logic [1:0]  rem_r;
   logic [7:0]  tx_data_r;
   logic        tx_valid_r;

   // Load on start, then advance one byte per accepted handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_r       <= 24'h000000;
         rem_r      <= 2'd0;
         tx_data_r  <= 8'h00;
         tx_valid_r <= 1'b0;
      end else if (start) begin
         tx_data_r  <= word[31:24];
         sh_r       <= word[23:0];
         rem_r      <= 2'(nbytes - 3'd1);
         tx_valid_r <= 1'b1;
      end else if (tx_valid_r && tx_ready) begin
         if (rem_r == 2'd0) begin
            tx_valid_r <= 1'b0;
         end else begin
            tx_data_r <= sh_r[23:16];
            sh_r      <= {sh_r[15:0], 8'h00};
            rem_r     <= rem_r - 2'd1;
         end
      end
   end

   assign tx_data  = tx_data_r;
   assign tx_valid = tx_valid_r;
   assign done     = tx_valid_r && tx_ready && (rem_r == 2'd0);

endmodule

// File: rtl/uart_wb_bridge.sv
// UART byte-stream to Wishbone master bridge: parses W/R frames, runs one bus
// cycle with timeout, returns the response bytes. Optional macro: UART_WB_CHECKSUM_EN.
module uart_wb_bridge
   import uart_wb_pkg::*;
#(
   parameter int          TIMEOUT = 1024,
   parameter logic [3:0]  SEL_ALL = 4'hF
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   output logic        busy,
   output logic        err_o
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   state_t            state_r, state_s;
   logic [1:0]        cnt_r, cnt_s;
   logic              we_r, we_s;
   logic [31:0]       adr_r, adr_s;
   logic [31:0]       dat_r, dat_s;
   logic              cyc_r, cyc_s;
   logic [TMO_W-1:0]  tmo_r, tmo_s;
   logic              err_r, err_s;
   logic              busy_r;
   logic              start_r, start_s;
   logic [31:0]       rsp_word_r, rsp_word_s;
   logic [2:0]        rsp_cnt_r, rsp_cnt_s;
   logic              ser_done_s;

`ifdef UART_WB_CHECKSUM_EN
   logic [7:0]        chk_r;

   // Running XOR over CMD, ADDR and DATA bytes of the current frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_r <= 8'h00;
      end else if (rx_valid && (state_r == ST_IDLE)) begin
         chk_r <= rx_data;
      end else if (rx_valid && ((state_r == ST_ADDR) || (state_r == ST_DATA))) begin
         chk_r <= chk_update(chk_r, rx_data);
      end
   end
`endif

   // Frame parser and bus sequencer next-state logic.
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      we_s       = we_r;
      adr_s      = adr_r;
      dat_s      = dat_r;
      cyc_s      = cyc_r;
      tmo_s      = tmo_r;
      err_s      = 1'b0;
      start_s    = 1'b0;
      rsp_word_s = rsp_word_r;
      rsp_cnt_s  = rsp_cnt_r;
      case (state_r)
         ST_IDLE: begin
            cnt_s = 2'd0;
            if (rx_valid) begin
               if (rx_data == CMD_WR) begin
                  we_s    = 1'b1;
                  state_s = ST_ADDR;
               end else if (rx_data == CMD_RD) begin
                  we_s    = 1'b0;
                  state_s = ST_ADDR;
               end else begin
                  rsp_word_s = rsp_word(RSP_BADCMD);
                  rsp_cnt_s  = 3'd1;
                  start_s    = 1'b1;
                  err_s      = 1'b1;
                  state_s    = ST_RESP;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ADDR: begin
            if (rx_valid) begin
               adr_s = {adr_r[23:0], rx_data};
               cnt_s = cnt_r + 2'd1;
               if (cnt_r == 2'd3) begin
                  if (we_r) begin
                     state_s = ST_DATA;
                  end else begin
`ifdef UART_WB_CHECKSUM_EN
                     state_s = ST_CHK;
`else
                     state_s = ST_BUS;
                     cyc_s   = 1'b1;
                     tmo_s   = {TMO_W{1'b0}};
`endif
                  end
               end else begin
                  state_s = ST_ADDR;
               end
            end else begin
               state_s = ST_ADDR;
            end
         end
         ST_DATA: begin
            if (rx_valid) begin
               dat_s = {dat_r[23:0], rx_data};
               cnt_s = cnt_r + 2'd1;
               if (cnt_r == 2'd3) begin
`ifdef UART_WB_CHECKSUM_EN
                  state_s = ST_CHK;
`else
                  state_s = ST_BUS;
                  cyc_s   = 1'b1;
                  tmo_s   = {TMO_W{1'b0}};
`endif
               end else begin
                  state_s = ST_DATA;
               end
            end else begin
               state_s = ST_DATA;
            end
         end
`ifdef UART_WB_CHECKSUM_EN
         ST_CHK: begin
            if (rx_valid) begin
               if (rx_data == chk_r) begin
                  state_s = ST_BUS;
                  cyc_s   = 1'b1;
                  tmo_s   = {TMO_W{1'b0}};
               end else begin
                  rsp_word_s = rsp_word(RSP_CHK);
                  rsp_cnt_s  = 3'd1;
                  start_s    = 1'b1;
                  err_s      = 1'b1;
                  state_s    = ST_RESP;
               end
            end else begin
               state_s = ST_CHK;
            end
         end
`endif
         ST_BUS: begin
            err_s = rx_valid;
            // Ack is checked before expiry so a last-cycle ack still completes.
            if (wbm_ack_i) begin
               cyc_s   = 1'b0;
               start_s = 1'b1;
               state_s = ST_RESP;
               if (we_r) begin
                  rsp_word_s = rsp_word(RSP_OK);
                  rsp_cnt_s  = 3'd1;
               end else begin
                  rsp_word_s = wbm_dat_i;
                  rsp_cnt_s  = 3'd4;
               end
            end else if (tmo_r == TMO_LAST) begin
               cyc_s      = 1'b0;
               rsp_word_s = rsp_word(RSP_TMO);
               rsp_cnt_s  = 3'd1;
               start_s    = 1'b1;
               err_s      = 1'b1;
               state_s    = ST_RESP;
            end else begin
               tmo_s = tmo_r + {{(TMO_W-1){1'b0}}, 1'b1};
            end
         end
         ST_RESP: begin
            err_s = rx_valid;
            if (ser_done_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RESP;
            end
         end
         default: begin
            state_s = ST_IDLE;
            cyc_s   = 1'b0;
         end
      endcase
   end

   // Bridge state and registered bus/status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         cnt_r      <= 2'd0;
         we_r       <= 1'b0;
         adr_r      <= 32'h00000000;
         dat_r      <= 32'h00000000;
         cyc_r      <= 1'b0;
         tmo_r      <= {TMO_W{1'b0}};
         err_r      <= 1'b0;
         busy_r     <= 1'b0;
         start_r    <= 1'b0;
         rsp_word_r <= 32'h00000000;
         rsp_cnt_r  <= 3'd0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         we_r       <= we_s;
         adr_r      <= adr_s;
         dat_r      <= dat_s;
         cyc_r      <= cyc_s;
         tmo_r      <= tmo_s;
         err_r      <= err_s;
         busy_r     <= (state_s != ST_IDLE);
         start_r    <= start_s;
         rsp_word_r <= rsp_word_s;
         rsp_cnt_r  <= rsp_cnt_s;
      end
   end

   uart_wb_resp_ser u_ser (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start_r),
      .word     (rsp_word_r),
      .nbytes   (rsp_cnt_r),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .done     (ser_done_s)
   );

   assign wbm_cyc_o = cyc_r;
   assign wbm_stb_o = cyc_r;
   assign wbm_we_o  = we_r;
   assign wbm_sel_o = SEL_ALL;
   assign wbm_adr_o = adr_r;
   assign wbm_dat_o = dat_r;
   assign busy      = busy_r;
   assign err_o     = err_r;

endmodule
